// File: rtl/cmos_cfg_pkg.sv
// Shared types and constants for the CMOS camera power-up configuration sequencer.
package cmos_cfg_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [15:0] REG_HSIZE_H = 16'h3808;
    localparam logic [15:0] REG_HSIZE_L = 16'h3809;
    localparam logic [15:0] REG_VSIZE_H = 16'h380A;
    localparam logic [15:0] REG_VSIZE_L = 16'h380B;

    localparam int ENTRY_W     = 24;
    localparam int REG_NUM_DEF = 250;

    function automatic int idx_width(input int reg_num);
        return (reg_num <= 2) ? 1 : $clog2(reg_num);
    endfunction

    localparam int IDX_W_DEF = idx_width(REG_NUM_DEF);

endpackage

// File: rtl/cmos_cfg_rom.sv
// Camera register table: combinational index -> {reg_addr[15:0], reg_data[7:0]}.
module cmos_cfg_rom
    import cmos_cfg_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    // Output-size registers lead the table; their data bytes are placeholders
    // that the sequencer replaces with the live capture resolution.
    always_comb begin
        entry = 24'h310303;
        case (32'(idx))
            0:       entry = 24'h380802;
            1:       entry = 24'h380980;
            2:       entry = 24'h380A01;
            3:       entry = 24'h380BE0;
            4:       entry = 24'h310311;
            5:       entry = 24'h300882;
            6:       entry = 24'h300842;
            7:       entry = 24'h310303;
            8:       entry = 24'h301700;
            9:       entry = 24'h301800;
            10:      entry = 24'h303411;
            11:      entry = 24'h303511;
            12:      entry = 24'h303646;
            13:      entry = 24'h303713;
            default: entry = 24'h310303;
        endcase
    end

endmodule

// File: rtl/cmos_cfg_seq.sv
// Power-up sequencer: walks the register table and issues one SCCB write per entry,
// patching the output-size registers with the capture resolution.
module cmos_cfg_seq
    import cmos_cfg_pkg::*;
#(
    parameter int REG_NUM   = 250,
    parameter int PWR_DLY   = 20000,
    parameter int GAP_DLY   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] h_pixel,
    input  logic [10:0] v_pixel,
    output logic        i2c_exec,
    output logic [23:0] i2c_data,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        init_done,
    output logic        cfg_err
);

    localparam int IDX_W = idx_width(REG_NUM);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_NUM - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [15:0]      PWR_LAST = 16'(PWR_DLY - 1);
    localparam logic [15:0]      GAP_LAST = 16'(GAP_DLY - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [RTY_W-1:0]    retry;
    logic [15:0]         dly_cnt;
    logic [10:0]         h_hold;
    logic [10:0]         v_hold;
    logic [ENTRY_W-1:0]  rom_entry;
    logic                sample_hv;

    cmos_cfg_rom #(.IDX_W(IDX_W)) u_rom (
        .idx   (idx),
        .entry (rom_entry)
    );

    function automatic logic [23:0] patch_entry(input logic [23:0] e,
                                                input logic [10:0] h,
                                                input logic [10:0] v);
        logic [7:0] d;
        d = e[7:0];
        case (e[23:8])
            REG_HSIZE_H: d = {5'b0, h[10:8]};
            REG_HSIZE_L: d = h[7:0];
            REG_VSIZE_H: d = {5'b0, v[10:8]};
            REG_VSIZE_L: d = v[7:0];
            default:     d = e[7:0];
        endcase
        return {e[23:8], d};
    endfunction

    // Resolution is captured once per sequence so every size write is consistent.
    assign sample_hv = ((state == ST_PWR_WAIT) && (dly_cnt == PWR_LAST)) ||
                       (((state == ST_DONE) || (state == ST_ERROR)) && start);

    always_ff @(posedge clk) begin
        if (sample_hv) begin
            h_hold <= h_pixel;
            v_hold <= v_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PWR_WAIT;
            idx       <= '0;
            retry     <= '0;
            dly_cnt   <= '0;
            i2c_exec  <= 1'b0;
            i2c_data  <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            i2c_exec <= 1'b0;
            case (state)
                ST_PWR_WAIT: begin
                    if (dly_cnt == PWR_LAST) state <= ST_ISSUE;
                    else                     dly_cnt <= dly_cnt + 1'b1;
                end
                ST_ISSUE: begin
                    i2c_exec <= 1'b1;
                    i2c_data <= patch_entry(rom_entry, h_hold, v_hold);
                    state    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i2c_done) begin
                        if (!i2c_ack) begin
                            retry <= '0;
                            if (idx == IDX_LAST) begin
                                state     <= ST_DONE;
                                busy      <= 1'b0;
                                init_done <= 1'b1;
                            end else begin
                                idx     <= idx + 1'b1;
                                dly_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end else if (retry != RTY_MAX) begin
                            retry   <= retry + 1'b1;
                            dly_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            state   <= ST_ERROR;
                            busy    <= 1'b0;
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (dly_cnt == GAP_LAST) state <= ST_ISSUE;
                    else                     dly_cnt <= dly_cnt + 1'b1;
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        idx       <= '0;
                        retry     <= '0;
                        dly_cnt   <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        cfg_err   <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Self-checking bench for cmos_cfg_seq: acts as the I2C master and predicts every write.
module tb_cmos_cfg_seq;

    localparam int REG_NUM   = 4;
    localparam int PWR_DLY   = 10;
    localparam int GAP_DLY   = 2;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] h_pixel = '0;
    logic [10:0] v_pixel = '0;
    logic        i2c_done = 1'b0;
    logic        i2c_ack = 1'b0;
    logic        i2c_exec;
    logic [23:0] i2c_data;
    logic        busy;
    logic        init_done;
    logic        cfg_err;

    cmos_cfg_seq #(
        .REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY), .GAP_DLY(GAP_DLY), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .h_pixel(h_pixel), .v_pixel(v_pixel),
        .i2c_exec(i2c_exec), .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .busy(busy), .init_done(init_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          nack_plan[REG_NUM];
    bit          inj_start = 0;
    bit          inj_done = 0;
    int          stop_at = -1;
    logic [10:0] hs, vs;
    logic [23:0] obs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Table entries 0..3 are the output-size registers 0x3808..0x380B.
    function automatic logic [23:0] exp_entry(input int i, input logic [10:0] h, input logic [10:0] v);
        logic [15:0] a;
        logic [7:0]  d;
        a = 16'h3808 + 16'(i);
        case (i)
            0:       d = {5'b0, h[10:8]};
            1:       d = h[7:0];
            2:       d = {5'b0, v[10:8]};
            default: d = v[7:0];
        endcase
        return {a, d};
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < REG_NUM; i++) nack_plan[i] = 0;
        inj_start = 0;
        inj_done  = 0;
        stop_at   = -1;
    endtask

    task automatic run_seq(input int first_wait);
        int q[$];
        int att[REG_NUM];
        bit exp_err;
        int cnt;
        exp_err = 0;
        obs.delete();
        for (int e = 0; e < REG_NUM; e++) begin
            att[e] = 0;
            if (nack_plan[e] > MAX_RETRY) begin
                repeat (MAX_RETRY + 1) q.push_back(e);
                exp_err = 1;
                break;
            end
            repeat (nack_plan[e] + 1) q.push_back(e);
        end
        cnt = 0;
        while (i2c_exec !== 1'b1 && cnt < first_wait + 20) begin tick(); cnt++; end
        tests++;
        if (i2c_exec !== 1'b1 || cnt != first_wait) begin
            fails++;
            $display("FAIL first_exec: exec=%b after %0d cycles, required 1 after %0d", i2c_exec, cnt, first_wait);
            return;
        end
        for (int k = 0; k < q.size(); k++) begin
            int          e;
            int          lat;
            bit          nack;
            logic [23:0] want;
            logic [23:0] held;
            bit          extra;
            e    = q[k];
            want = exp_entry(e, hs, vs);
            tests++;
            if (i2c_data !== want) begin
                fails++;
                $display("FAIL write_data[%0d]: i2c_data=%h, required %h", k, i2c_data, want);
            end
            obs.push_back(i2c_data);
            held = i2c_data;
            if (e == stop_at) return;
            lat = $urandom_range(1, 5);
            for (int j = 0; j < lat; j++) begin
                h_pixel = 11'($urandom);
                v_pixel = 11'($urandom);
                start   = inj_start && (j == 0);
                tick();
                tests++;
                if (i2c_exec !== 1'b0 || i2c_data !== held || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL hold[%0d]: exec=%b data=%h busy=%b, required 0 %h 1", k, i2c_exec, i2c_data, busy, held);
                end
            end
            start = 1'b0;
            nack  = att[e] < nack_plan[e];
            att[e]++;
            i2c_done = 1'b1;
            i2c_ack  = nack;
            tick();
            i2c_ack  = 1'b0;
            if (k == q.size() - 1) begin
                i2c_done = 1'b0;
                tests++;
                if (init_done !== !exp_err || cfg_err !== exp_err || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL end_status: init_done=%b cfg_err=%b busy=%b, required %b %b 0", init_done, cfg_err, busy, !exp_err, exp_err);
                end
                extra = 0;
                repeat (12) begin tick(); if (i2c_exec === 1'b1) extra = 1; end
                tests++;
                if (extra || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_after_end: extra_exec=%b busy=%b, required 0 0", extra, busy);
                end
            end else begin
                // A spurious done during GAP (inj_done) must not disturb the sequence.
                i2c_done = inj_done;
                cnt = 1;
                while (i2c_exec !== 1'b1 && cnt < GAP_DLY + 22) begin tick(); cnt++; i2c_done = 1'b0; end
                i2c_done = 1'b0;
                tests++;
                if (i2c_exec !== 1'b1 || cnt != GAP_DLY + 2) begin
                    fails++;
                    $display("FAIL next_exec[%0d]: exec=%b after %0d cycles, required 1 after %0d", k, i2c_exec, cnt, GAP_DLY + 2);
                    return;
                end
            end
        end
    endtask

    task automatic restart();
        hs = 11'($urandom);
        vs = 11'($urandom);
        h_pixel = hs;
        v_pixel = vs;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || init_done !== 1'b0 || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL restart_status: busy=%b init_done=%b cfg_err=%b, required 1 0 0", busy, init_done, cfg_err);
        end
        run_seq(GAP_DLY + 1);
    endtask

    task automatic test_reset();
        clear_plan();
        hs = 11'd800;
        vs = 11'd480;
        h_pixel = hs;
        v_pixel = vs;
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (i2c_exec !== 1'b0 || i2c_data !== 24'h0 || busy !== 1'b1 || init_done !== 1'b0 || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: exec=%b data=%h busy=%b init_done=%b cfg_err=%b, required 0 000000 1 0 0",
                     i2c_exec, i2c_data, busy, init_done, cfg_err);
        end
        rst_n = 1'b1;
        run_seq(PWR_DLY + 1);
    endtask

    task automatic test_patch_fixed();
        logic [23:0] lit[4];
        lit[0] = 24'h380803;
        lit[1] = 24'h380920;
        lit[2] = 24'h380A01;
        lit[3] = 24'h380BE0;
        tests++;
        if (obs.size() != 4) begin
            fails++;
            $display("FAIL patch_count: %0d writes, required 4", obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (obs[i] !== lit[i]) begin
                    fails++;
                    $display("FAIL patch_800x480[%0d]: %h, required %h", i, obs[i], lit[i]);
                end
            end
        end
    endtask

    task automatic test_retry();
        clear_plan();
        nack_plan[2] = 2;
        restart();
        tests++;
        if (obs.size() != 6 || obs[2] !== obs[3] || obs[3] !== obs[4] || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL retry_repeat: writes=%0d cfg_err=%b, required 6 writes with identical retries and cfg_err 0", obs.size(), cfg_err);
        end
    endtask

    task automatic test_abort();
        clear_plan();
        nack_plan[1] = 4;
        restart();
        tests++;
        if (obs.size() != 5 || cfg_err !== 1'b1) begin
            fails++;
            $display("FAIL abort: writes=%0d cfg_err=%b, required 5 and 1", obs.size(), cfg_err);
        end
        clear_plan();
        restart();
    endtask

    task automatic test_back_to_back();
        clear_plan();
        inj_start = 1;
        inj_done  = 1;
        restart();
        tests++;
        if (obs.size() != REG_NUM || init_done !== 1'b1) begin
            fails++;
            $display("FAIL spurious_inputs: writes=%0d init_done=%b, required %0d and 1", obs.size(), init_done, REG_NUM);
        end
    endtask

    task automatic test_reset_mid();
        clear_plan();
        stop_at = 2;
        restart();
        tick();
        i2c_done = 1'b1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (i2c_exec !== 1'b0 || i2c_data !== 24'h0 || busy !== 1'b1 || init_done !== 1'b0 || cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: exec=%b data=%h busy=%b init_done=%b cfg_err=%b, required 0 000000 1 0 0",
                     i2c_exec, i2c_data, busy, init_done, cfg_err);
        end
        tick();
        i2c_done = 1'b0;
        tick();
        clear_plan();
        hs = 11'($urandom);
        vs = 11'($urandom);
        h_pixel = hs;
        v_pixel = vs;
        rst_n = 1'b1;
        run_seq(PWR_DLY + 1);
        tests++;
        if (obs.size() != REG_NUM || init_done !== 1'b1) begin
            fails++;
            $display("FAIL reset_restart: writes=%0d init_done=%b, required %0d and 1", obs.size(), init_done, REG_NUM);
        end
    endtask

    initial begin
        test_reset();
        test_patch_fixed();
        test_retry();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
